// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: control-bit positions, widths and the MEM/WB latch layout
package mem_stage_pkg;
  localparam int MEMWRITE_BIT = 1;
  localparam int MEMREAD_BIT = 0;
  localparam int CTLWB_W = 2;
  localparam int WORD_BYTES = 4;
  typedef struct packed {
    logic [CTLWB_W-1:0] ctlwb;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0] muxout;
  } memwb_t;
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: word RAM, zero at power-up, synchronous write and asynchronous read
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input logic clk,
  input logic we_i,
  input logic [ADDR_W-1:0] addr_i,
  input logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: word load/store against data memory, MEM/WB latch and first-fault capture
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input logic clk,
  input logic rst_n,
  input logic [CTLWB_W-1:0] ctlwb_in,
  input logic [1:0] ctlm_in,
  input logic [31:0] alu_result_in,
  input logic [31:0] rdata2_in,
  input logic [4:0] muxout_in,
  output logic [CTLWB_W-1:0] ctlwb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0] muxout_out,
  output logic mem_err,
  output logic [31:0] err_addr
);
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int HI_SHIFT = ADDR_W + OFF_W;
  logic rd, wr, aligned, in_range, legal, fault;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem_rdata, err_addr_d, err_addr_q;
  logic err_d, err_q;
  memwb_t memwb_d, memwb_q;
  always_comb begin
    rd = ctlm_in[MEMREAD_BIT];
    wr = ctlm_in[MEMWRITE_BIT];
    idx = alu_result_in[HI_SHIFT-1:OFF_W];
    aligned = alu_result_in[OFF_W-1:0] == '0;
    in_range = (alu_result_in >> HI_SHIFT) == 32'd0;
    legal = aligned && in_range && !(rd && wr);
    fault = (rd || wr) && !legal;
    memwb_d.ctlwb = fault ? '0 : ctlwb_in;
    memwb_d.read_data = rd && legal ? mem_rdata : '0;
    memwb_d.alu_result = alu_result_in;
    memwb_d.muxout = muxout_in;
    err_d = err_q || fault;
    err_addr_d = fault && !err_q ? alu_result_in : err_addr_q;
  end
  // rst_n gates the write so a store presented during reset is dropped
  data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) u_dmem (
    .clk(clk),
    .we_i(wr && legal && rst_n),
    .addr_i(idx),
    .wdata_i(rdata2_in),
    .rdata_o(mem_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      memwb_q <= '0;
      err_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      memwb_q <= memwb_d;
      err_q <= err_d;
      err_addr_q <= err_addr_d;
    end
  assign ctlwb_out = memwb_q.ctlwb;
  assign read_data_out = memwb_q.read_data;
  assign alu_result_out = memwb_q.alu_result;
  assign muxout_out = memwb_q.muxout;
  assign mem_err = err_q;
  assign err_addr = err_addr_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random stimulus checked against an array-based memory model
module tb_mem_stage;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] ctlwb_in = '0, ctlm_in = '0;
  logic [31:0] alu_result_in = '0, rdata2_in = '0;
  logic [4:0] muxout_in = '0;
  logic [1:0] ctlwb_out;
  logic [31:0] read_data_out, alu_result_out, err_addr;
  logic [4:0] muxout_out;
  logic mem_err;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [31:0] mdl [DEPTH];
  bit m_err;
  logic [31:0] m_eaddr;
  logic [1:0] exp_ctlwb;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0] exp_mux;

  mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
    .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
    .ctlwb_out(ctlwb_out), .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .muxout_out(muxout_out), .mem_err(mem_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic zero_model();
    exp_ctlwb = '0; exp_rd = '0; exp_alu = '0; exp_mux = '0;
    m_err = 1'b0; m_eaddr = '0;
  endtask

  // one rising edge as the rules describe it: legality, then read-before-write
  task automatic model_edge();
    bit r, w, ok;
    int unsigned i;
    r = ctlm_in[0];
    w = ctlm_in[1];
    ok = (alu_result_in % 4 == 0) && (alu_result_in < 32'(DEPTH * 4)) && !(r && w);
    i = alu_result_in / 4;
    if (!rst_n) zero_model();
    else begin
      exp_alu = alu_result_in;
      exp_mux = muxout_in;
      if ((r || w) && !ok) begin
        exp_ctlwb = 2'b00;
        exp_rd = '0;
        if (!m_err) begin m_err = 1'b1; m_eaddr = alu_result_in; end
      end else begin
        exp_ctlwb = ctlwb_in;
        exp_rd = r ? mdl[i] : 32'h0;
        if (w) mdl[i] = rdata2_in;
      end
    end
  endtask

  task automatic step(bit r, logic [1:0] wb, logic [1:0] m, logic [31:0] a, logic [31:0] d, logic [4:0] x);
    rst_n = r; ctlwb_in = wb; ctlm_in = m; alu_result_in = a; rdata2_in = d; muxout_in = x;
    if (!r) begin
      zero_model();
      #1;
      check("async_clear_ctlwb", 32'(ctlwb_out), 32'h0);
      check("async_clear_rd", read_data_out, 32'h0);
      check("async_clear_err", 32'(mem_err), 32'h0);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk)
    if (chk_en) begin
      check("cmp_ctlwb", 32'(ctlwb_out), 32'(exp_ctlwb));
      check("cmp_read_data", read_data_out, exp_rd);
      check("cmp_alu_result", alu_result_out, exp_alu);
      check("cmp_muxout", 32'(muxout_out), 32'(exp_mux));
      check("cmp_mem_err", 32'(mem_err), 32'(m_err));
      check("cmp_err_addr", err_addr, m_eaddr);
    end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    zero_model();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (3) step(1'b0, 2'($urandom), 2'b10, $urandom, $urandom, 5'($urandom));
    check("rst_alu_out", alu_result_out, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    step(1'b1, 2'b11, 2'b10, 32'h10, 32'hDEADBEEF, 5'd1);
    step(1'b1, 2'b01, 2'b01, 32'h10, 32'h0, 5'd2);
    check("lit_load_deadbeef", read_data_out, 32'hDEADBEEF);
    step(1'b1, 2'b10, 2'b00, 32'h1234, 32'h5555, 5'd7);
    check("lit_pass_alu", alu_result_out, 32'h1234);
    check("lit_pass_mux", 32'(muxout_out), 32'd7);
    check("lit_pass_ctlwb", 32'(ctlwb_out), 32'h2);
    check("lit_pass_rd", read_data_out, 32'h0);
    step(1'b1, 2'b01, 2'b10, 32'h0, 32'hCAFE0000, 5'd3);
    step(1'b1, 2'b01, 2'b10, 32'h3FC, 32'h11112222, 5'd4);
    check("lit_top_store_no_err", 32'(mem_err), 32'h0);
    step(1'b1, 2'b11, 2'b10, 32'h400, 32'h99999999, 5'd5);
    check("lit_oob_err", 32'(mem_err), 32'h1);
    check("lit_oob_addr", err_addr, 32'h400);
    check("lit_oob_ctlwb", 32'(ctlwb_out), 32'h0);
    step(1'b1, 2'b01, 2'b01, 32'h0, 32'h0, 5'd6);
    check("lit_no_alias", read_data_out, 32'hCAFE0000);
    step(1'b1, 2'b01, 2'b01, 32'h3FC, 32'h0, 5'd6);
    check("lit_top_load", read_data_out, 32'h11112222);
    step(1'b1, 2'b01, 2'b10, 32'h20, 32'h20202020, 5'd8);
    step(1'b0, 2'b11, 2'b10, 32'h20, 32'hBAD0BAD0, 5'd9);
    step(1'b1, 2'b01, 2'b01, 32'h20, 32'h0, 5'd10);
    check("lit_reset_drop_store", read_data_out, 32'h20202020);
    check("lit_reset_err_clear", 32'(mem_err), 32'h0);
    step(1'b1, 2'b01, 2'b01, 32'h22, 32'h0, 5'd11);
    check("lit_misaligned_rd", read_data_out, 32'h0);
    check("lit_misaligned_err", 32'(mem_err), 32'h1);
    check("lit_misaligned_addr", err_addr, 32'h22);
    step(1'b1, 2'b01, 2'b10, 32'h401, 32'h1, 5'd12);
    check("lit_first_fault_kept", err_addr, 32'h22);
    step(1'b1, 2'b01, 2'b10, 32'h8, 32'h88, 5'd13);
    step(1'b1, 2'b01, 2'b11, 32'h8, 32'h77, 5'd14);
    step(1'b1, 2'b01, 2'b01, 32'h8, 32'h0, 5'd15);
    check("lit_rw_conflict_no_write", read_data_out, 32'h88);
    step(1'b1, 2'b01, 2'b10, 32'h8, 32'h1, 5'd16);
    step(1'b1, 2'b01, 2'b10, 32'h8, 32'h2, 5'd17);
    step(1'b1, 2'b01, 2'b01, 32'h8, 32'h0, 5'd18);
    check("lit_last_write_wins", read_data_out, 32'h2);
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        6: a = 32'($urandom_range(DEPTH - 8, DEPTH - 1)) * 4;
        7: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        8: a = 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
        9: a = $urandom;
        default: a = 32'($urandom_range(0, 15)) * 4;
      endcase
      step($urandom_range(0, 39) != 0, 2'($urandom), 2'($urandom), a, $urandom, 5'($urandom));
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
